mem_dump_unit: RTL and testbench

MEM_DUMP_UNIT -- requirements
Module: mem_dump_unit

---
 rtl/mem_dump_unit_pkg.sv | 33 +++
 rtl/mem_dump_unit_if.sv | 24 ++
 rtl/mem_dump_unit_word_serializer.sv | 52 +++++
 rtl/mem_dump_unit.sv | 114 +++++++++++
 tb/tb_mem_dump_unit.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_dump_unit_pkg.sv
// Shared pipeline package: dump-unit state encoding, word geometry and the
// load/store opcode constants used by the core that owns the data memory.
package mem_dump_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LATCH,
    ST_SEND,
    ST_WAIT_TX,
    ST_NEXT,
    ST_DONE
  } dump_state_e;

  localparam int DATA_W         = 32;
  localparam int BYTES_PER_WORD = DATA_W / 8;

  // Load/store opcodes and word-access funct3 of the pipeline.
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [2:0] F3_WORD   = 3'b010;

  // Byte count for an arbitrary word width (the BYTES_PER_WORD rule, generalised).
  function automatic int bytes_per_word(input int w);
    return w / 8;
  endfunction

  // Counter width that can hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_dump_unit_if.sv
// Memory-read and UART-transmit bus of the dump unit.
//   master : dump unit side (drives read strobe/address and tx byte/strobe)
//   slave  : memory + transmitter side (returns read word and tx done tick)
interface mem_dump_unit_if #(
  parameter int B      = 32,
  parameter int ADDR_W = 8
) ();
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [B-1:0]      mem_rdata;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_done_tick;

  modport master (
    output mem_rd_en, mem_addr, tx_data, tx_start,
    input  mem_rdata, tx_done_tick
  );

  modport slave (
    input  mem_rd_en, mem_addr, tx_data, tx_start,
    output mem_rdata, tx_done_tick
  );
endinterface

// File: rtl/mem_dump_unit_word_serializer.sv
// word_serializer: holds one B-bit word and hands it out MSB byte first.
//   load/load_data : capture a new word, byte counter to 0
//   shift          : shift left by 8, byte counter +1
//   clr            : byte counter to 0 (word untouched)
//   next_byte      : byte that becomes the top byte after the next shift
//   last_byte      : counter is on the final byte of the word
module word_serializer
  import mem_dump_unit_pkg::*;
#(
  parameter int B = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [B-1:0] load_data,
  input  logic         shift,
  input  logic         clr,
  output logic [7:0]   next_byte,
  output logic         last_byte
);
  localparam int BPW = bytes_per_word(B);
  localparam int BCW = cnt_w(BPW);

  logic [B-1:0]   shift_q;
  logic [BCW-1:0] byte_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      shift_q  <= load_data;
      byte_cnt <= '0;
    end else if (shift) begin
      shift_q  <= shift_q << 8;
      byte_cnt <= byte_cnt + 1'b1;
    end else if (clr) begin
      byte_cnt <= '0;
    end
  end

  assign last_byte = (byte_cnt == BCW'(BPW - 1));

  // Looking one byte ahead lets the FSM register tx_data on the same edge
  // that performs the shift, so tx_data is valid together with tx_start.
  if (B > 8) begin : g_next
    assign next_byte = shift_q[B-9 -: 8];
  end else begin : g_single
    assign next_byte = '0;
  end

endmodule

// File: rtl/mem_dump_unit.sv
// mem_dump_unit: on start, reads N_WORDS consecutive data-memory words from
// base_addr (wrapping at 2^ADDR_W) and sends each word MSB byte first to a
// UART transmitter, one byte per tx_done_tick.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start/base_addr : dump request and first word address (IDLE only)
//   bus (master)    : mem_rd_en/mem_addr/mem_rdata, tx_data/tx_start/tx_done_tick
//   busy            : high in every state but IDLE
//   done            : one-cycle pulse at the end of a completed dump
// All strobes are registered and asserted on entry to their state, so they
// are high exactly while the FSM sits in READ / SEND / DONE.
module mem_dump_unit
  import mem_dump_unit_pkg::*;
#(
  parameter int B       = 32,
  parameter int ADDR_W  = 8,
  parameter int N_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  mem_dump_unit_if.master   bus,
  output logic              busy,
  output logic              done
);
  localparam int WCW = ADDR_W + 1;

  dump_state_e       state;
  logic [ADDR_W-1:0] addr_q;
  logic [WCW-1:0]    word_cnt;

  logic       ser_load, ser_shift, ser_clr;
  logic [7:0] next_byte;
  logic       last_byte;
  logic       last_word;

  assign last_word = (word_cnt == WCW'(N_WORDS - 1));
  assign ser_load  = (state == ST_LATCH);
  assign ser_shift = (state == ST_WAIT_TX) && bus.tx_done_tick;
  assign ser_clr   = ((state == ST_IDLE) && start) || ((state == ST_NEXT) && !last_word);

  word_serializer #(.B(B)) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ser_load),
    .load_data (bus.mem_rdata),
    .shift     (ser_shift),
    .clr       (ser_clr),
    .next_byte (next_byte),
    .last_byte (last_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      addr_q        <= '0;
      word_cnt      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.mem_rd_en <= 1'b0;
      bus.mem_addr  <= '0;
      bus.tx_start  <= 1'b0;
      bus.tx_data   <= '0;
    end else begin
      bus.mem_rd_en <= 1'b0;
      bus.tx_start  <= 1'b0;
      done          <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          addr_q        <= base_addr;
          word_cnt      <= '0;
          bus.mem_addr  <= base_addr;
          bus.mem_rd_en <= 1'b1;
          busy          <= 1'b1;
          state         <= ST_READ;
        end
        ST_READ:  state <= ST_LATCH;
        // mem_rdata is valid now; the serializer captures it on this edge,
        // so the first byte is taken straight from the read word.
        ST_LATCH: begin
          bus.tx_data  <= bus.mem_rdata[B-1 -: 8];
          bus.tx_start <= 1'b1;
          state        <= ST_SEND;
        end
        ST_SEND:  state <= ST_WAIT_TX;
        ST_WAIT_TX: if (bus.tx_done_tick) begin
          if (!last_byte) begin
            bus.tx_data  <= next_byte;
            bus.tx_start <= 1'b1;
            state        <= ST_SEND;
          end else begin
            state <= ST_NEXT;
          end
        end
        ST_NEXT: if (last_word) begin
          done  <= 1'b1;
          state <= ST_DONE;
        end else begin
          word_cnt      <= word_cnt + 1'b1;
          addr_q        <= addr_q + 1'b1;
          bus.mem_addr  <= addr_q + 1'b1;
          bus.mem_rd_en <= 1'b1;
          state         <= ST_READ;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_unit.sv
// Scoreboard bench: two instances (N_WORDS=1 and N_WORDS=4) share one clock,
// reset and memory model. Stimulus pushes expected addresses/bytes; a
// negedge monitor pops and compares on every mem_rd_en / tx_start.
module tb_mem_dump_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       st;
  logic [1:0][7:0]  ba;
  logic [1:0][31:0] rdata;
  logic [1:0]       tick_m, tick_x, inj_send;
  logic [1:0]       ts, re, dn, bz;
  logic [1:0][7:0]  td, ma;

  mem_dump_unit_if #(.B(32), .ADDR_W(8)) if1 ();
  mem_dump_unit_if #(.B(32), .ADDR_W(8)) if4 ();

  mem_dump_unit #(.B(32), .ADDR_W(8), .N_WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .base_addr(ba[0]),
    .bus(if1), .busy(bz[0]), .done(dn[0]));
  mem_dump_unit #(.B(32), .ADDR_W(8), .N_WORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .base_addr(ba[1]),
    .bus(if4), .busy(bz[1]), .done(dn[1]));

  assign if1.mem_rdata    = rdata[0];
  assign if4.mem_rdata    = rdata[1];
  assign if1.tx_done_tick = tick_m[0] | tick_x[0];
  assign if4.tx_done_tick = tick_m[1] | tick_x[1];
  assign ts = {if4.tx_start,  if1.tx_start};
  assign re = {if4.mem_rd_en, if1.mem_rd_en};
  assign td = {if4.tx_data,   if1.tx_data};
  assign ma = {if4.mem_addr,  if1.mem_addr};

  logic [31:0] mem [256];
  logic [7:0]  exp_a [2][$];
  logic [7:0]  exp_b [2][$];
  int          ts_cyc [2][$];
  int          txn [2];
  int          donen [2];
  logic [1:0]  re_prev;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          txcnt [2];
  logic [7:0]  mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int k, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h @%0t", nm, k, act, expv, $time);
    end
  endfunction

  // Memory: word valid on the cycle after the read strobe.
  // Transmitter: done tick 10 cycles after each tx_start; optionally a
  // stray tick in the SEND cycle itself.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (re[k]) rdata[k] = mem[ma[k]];
      tick_m[k] = 1'b0;
      if (!rst_n) txcnt[k] = 0;
      else begin
        if (txcnt[k] != 0) begin
          txcnt[k]--;
          if (txcnt[k] == 0) tick_m[k] = 1'b1;
        end
        if (ts[k]) begin
          txcnt[k] = 10;
          if (inj_send[k]) tick_m[k] = 1'b1;
        end
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_n) begin
        if (re[k]) begin
          chk("rd_en_single", k, int'(re_prev[k]), 0);
          if (exp_a[k].size() == 0) chk("rd_unexpected", k, int'(re[k]), 0);
          else begin
            mon_e = exp_a[k].pop_front();
            chk("mem_addr", k, int'(ma[k]), int'(mon_e));
          end
        end
        if (ts[k]) begin
          txn[k]++;
          ts_cyc[k].push_back(cyc);
          if (exp_b[k].size() == 0) chk("tx_unexpected", k, int'(ts[k]), 0);
          else begin
            mon_e = exp_b[k].pop_front();
            chk("tx_data", k, int'(td[k]), int'(mon_e));
          end
        end
        if (dn[k]) donen[k]++;
      end
      re_prev[k] = re[k];
    end
  end

  task automatic push_word(input int k, input logic [7:0] a);
    logic [31:0] w;
    w = mem[a];
    exp_a[k].push_back(a);
    for (int i = 3; i >= 0; i--) exp_b[k].push_back(w[i*8 +: 8]);
  endtask

  task automatic do_start(input int k, input logic [7:0] a, output int st_c);
    @(negedge clk);
    ba[k] = a;
    st[k] = 1'b1;
    st_c = cyc;
    @(negedge clk);
    st[k] = 1'b0;
  endtask

  // Bounded wait for done, then check completion, pulse width and byte count.
  task automatic finish_run(input int k, input int t0, input int d0, input int nbytes, input int st_c);
    int lat;
    for (int i = 0; i < 1000 && donen[k] == d0; i++) @(negedge clk);
    chk("done_seen", k, donen[k] - d0, 1);
    repeat (3) @(negedge clk);
    chk("done_single", k, donen[k] - d0, 1);
    chk("busy_after", k, int'(bz[k]), 0);
    chk("tx_count", k, txn[k] - t0, nbytes);
    chk("bytes_left", k, exp_b[k].size(), 0);
    chk("addrs_left", k, exp_a[k].size(), 0);
    // The start cycle (IDLE) is the first of four; SEND is the fourth,
    // i.e. 3 clock edges after the edge that accepted start.
    lat = (ts_cyc[k].size() > t0) ? ts_cyc[k][t0] - st_c : -1;
    chk("start_latency", k, lat, 3);
  endtask

  initial begin
    int t0, d0, stc;
    st = '0; ba = '0; tick_x = '0; inj_send = '0; rdata = '0; tick_m = '0;
    re_prev = '0; txn = '{0, 0}; donen = '{0, 0}; txcnt = '{0, 0};
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h00] = 32'hDEADBEEF; mem[8'h01] = 32'hA1B2C3D4;
    mem[8'hFE] = 32'h01020304; mem[8'hFF] = 32'h05060708;
    mem[8'h10] = 32'h11223344; mem[8'h11] = 32'h55667788;
    mem[8'h12] = 32'h99AABBCC; mem[8'h13] = 32'hDDEEFF00;
    mem[8'h20] = 32'hCAFEF00D; mem[8'h21] = 32'h87654321;

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", k, int'(bz[k]), 0);  chk("rst_done", k, int'(dn[k]), 0);
      chk("rst_tx_start", k, int'(ts[k]), 0); chk("rst_rd_en", k, int'(re[k]), 0);
      chk("rst_tx_data", k, int'(td[k]), 0);  chk("rst_mem_addr", k, int'(ma[k]), 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single word DEADBEEF -> DE,AD,BE,EF then one done.
    push_word(0, 8'h00);
    t0 = txn[0]; d0 = donen[0];
    do_start(0, 8'h00, stc);
    finish_run(0, t0, d0, 4, stc);

    // Stray tick while idle must not start anything.
    @(negedge clk); tick_x[1] = 1'b1;
    @(negedge clk); tick_x[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_tick_busy", 1, int'(bz[1]), 0);

    // Four words from 0xFE with wrap; stray ticks in every SEND cycle.
    inj_send[1] = 1'b1;
    push_word(1, 8'hFE); push_word(1, 8'hFF); push_word(1, 8'h00); push_word(1, 8'h01);
    t0 = txn[1]; d0 = donen[1];
    do_start(1, 8'hFE, stc);
    finish_run(1, t0, d0, 16, stc);
    inj_send[1] = 1'b0;

    // start re-pulsed during WAIT_TX is ignored.
    for (int a = 8'h10; a <= 8'h13; a++) push_word(1, 8'(a));
    t0 = txn[1]; d0 = donen[1];
    do_start(1, 8'h10, stc);
    for (int i = 0; i < 200 && txn[1] - t0 < 2; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    ba[1] = 8'h80; st[1] = 1'b1;
    @(negedge clk); st[1] = 1'b0;
    finish_run(1, t0, d0, 16, stc);

    // Reset one cycle after the 6th byte: abort, no done, then a fresh run.
    exp_a[1].push_back(8'h20); exp_a[1].push_back(8'h21);
    exp_b[1].push_back(8'hCA); exp_b[1].push_back(8'hFE);
    exp_b[1].push_back(8'hF0); exp_b[1].push_back(8'h0D);
    exp_b[1].push_back(8'h87); exp_b[1].push_back(8'h65);
    t0 = txn[1]; d0 = donen[1];
    do_start(1, 8'h20, stc);
    for (int i = 0; i < 500 && txn[1] - t0 < 6; i++) @(negedge clk);
    chk("pre_reset_bytes", 1, txn[1] - t0, 6);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_busy", 1, int'(bz[1]), 0);  chk("mid_rst_done", 1, int'(dn[1]), 0);
    chk("mid_rst_tx_start", 1, int'(ts[1]), 0); chk("mid_rst_rd_en", 1, int'(re[1]), 0);
    chk("mid_rst_tx_data", 1, int'(td[1]), 0);  chk("mid_rst_mem_addr", 1, int'(ma[1]), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 1, donen[1] - d0, 0);
    chk("abort_no_tx", 1, txn[1] - t0, 6);
    chk("abort_idle", 1, int'(bz[1]), 0);
    push_word(1, 8'hFE); push_word(1, 8'hFF); push_word(1, 8'h00); push_word(1, 8'h01);
    t0 = txn[1]; d0 = donen[1];
    do_start(1, 8'hFE, stc);
    finish_run(1, t0, d0, 16, stc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
